// File: rtl/load_store_unit.sv
// Data-memory access unit: one load/store per request over a req/ack bus with byte enables.
// Optional macro MISALIGN_TRAP_EN makes misaligned accesses fault instead of reaching memory.
module load_store_unit #(
    parameter int WORDSIZE   = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORDSIZE-1:0]   wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WORDSIZE-1:0]   rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_be,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE,
        FAULT
    } state_t;

    state_t state, next_state;

    logic       we_q;
    logic [2:0] funct3_q;
    logic [2:0] off_q;

    logic [15:0] be_wide;
    logic [7:0]  be_base;
    logic        invalid;
    logic        misaligned;
    logic [63:0] lane_data;
    logic [63:0] load_ext;

    // Request decode: byte enables may shift past lane 7; only the low byte is kept.
    always_comb begin
        be_base = 8'h00;
        case (funct3[1:0])
            2'd0: be_base = 8'h01;
            2'd1: be_base = 8'h03;
            2'd2: be_base = 8'h0F;
            2'd3: be_base = 8'hFF;
            default: be_base = 8'h00;
        endcase
        be_wide = {8'h00, be_base} << addr[2:0];

        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (funct3[1:0])
            2'd1: misaligned = addr[0];
            2'd2: misaligned = (addr[1:0] != 2'b00);
            2'd3: misaligned = (addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
`endif
        invalid = (funct3 == 3'b111) || (we && funct3[2]) || misaligned;
    end

    always_comb begin
        lane_data = mem_rdata >> {off_q, 3'b000};
        load_ext  = '0;
        case (funct3_q)
            3'b000: load_ext = {{56{lane_data[7]}}, lane_data[7:0]};
            3'b001: load_ext = {{48{lane_data[15]}}, lane_data[15:0]};
            3'b010: load_ext = {{32{lane_data[31]}}, lane_data[31:0]};
            3'b011: load_ext = lane_data;
            3'b100: load_ext = {56'd0, lane_data[7:0]};
            3'b101: load_ext = {48'd0, lane_data[15:0]};
            3'b110: load_ext = {32'd0, lane_data[31:0]};
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = (state == DONE) || (state == FAULT);
        err        = (state == FAULT);
        case (state)
            IDLE:    if (req) next_state = invalid ? FAULT : ISSUE;
            ISSUE:   if (mem_ack) next_state = DONE;
            DONE:    next_state = IDLE;
            FAULT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        funct3_q <= funct3;
                        off_q    <= addr[2:0];
                        if (!invalid) begin
                            mem_req   <= 1'b1;
                            mem_we    <= we;
                            mem_addr  <= {addr[ADDR_WIDTH-1:3], 3'b000};
                            mem_wdata <= wdata << {addr[2:0], 3'b000};
                            mem_be    <= be_wide[7:0];
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        if (!we_q) rdata <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit; honours MISALIGN_TRAP_EN in its expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_rd = '0;

    always #5 clk = ~clk;

    load_store_unit #(.WORDSIZE(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrd;
        int unsigned waits;
        logic        exp_err;
        logic [7:0]  exp_be;
        logic [63:0] exp_maddr;
        logic [63:0] exp_mwdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic run_vec(input vec_t v);
        req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        req = 1'b0;
        if (v.exp_err) begin
            chk("fault_done", {63'd0, done}, 64'd1);
            chk("fault_err", {63'd0, err}, 64'd1);
            chk("fault_no_mem_req", {63'd0, mem_req}, 64'd0);
            chk("fault_rdata_hold", rdata, last_rd);
        end else begin
            chk("issue_mem_req", {63'd0, mem_req}, 64'd1);
            chk("issue_mem_we", {63'd0, mem_we}, {63'd0, v.we});
            chk("issue_mem_addr", mem_addr, v.exp_maddr);
            chk("issue_mem_be", {56'd0, mem_be}, {56'd0, v.exp_be});
            chk("issue_mem_wdata", mem_wdata, v.exp_mwdata);
            chk("issue_done_low", {63'd0, done}, 64'd0);
            for (int unsigned i = 0; i < v.waits; i++) begin
                @(negedge clk);
                chk("wait_mem_req", {63'd0, mem_req}, 64'd1);
                chk("wait_mem_be", {56'd0, mem_be}, {56'd0, v.exp_be});
                chk("wait_done_low", {63'd0, done}, 64'd0);
            end
            mem_ack = 1'b1; mem_rdata = v.mrd;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            if (!v.we) last_rd = v.exp_rdata;
            chk("done_pulse", {63'd0, done}, 64'd1);
            chk("done_err", {63'd0, err}, 64'd0);
            chk("done_mem_req", {63'd0, mem_req}, 64'd0);
            chk("done_mem_be", {56'd0, mem_be}, 64'd0);
            chk("done_rdata", rdata, last_rd);
        end
        @(negedge clk);
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_rdata", rdata, last_rd);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0, 1'b0, 8'hFF, 64'h10, 64'h1122334455667788, 64'h0};
        vecs[1]  = '{1'b0, 3'b000, 64'h23, 64'h0, 64'h0000000080000000, 0, 1'b0, 8'h08, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 64'h23, 64'h0, 64'h0000000080000000, 1, 1'b0, 8'h08, 64'h20, 64'h0, 64'h80};
        vecs[3]  = '{1'b1, 3'b001, 64'h06, 64'hABCD, 64'h0, 3, 1'b0, 8'hC0, 64'h0, 64'hABCD000000000000, 64'h0};
`ifdef MISALIGN_TRAP_EN
        vecs[4]  = '{1'b0, 3'b010, 64'h02, 64'h0, 64'h1122334455667788, 0, 1'b1, 8'h00, 64'h0, 64'h0, 64'h0};
        vecs[12] = '{1'b1, 3'b010, 64'h07, 64'hDEADBEEF, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'h0, 64'h0};
        vecs[14] = '{1'b0, 3'b011, 64'h03, 64'h0, 64'h1122334455667788, 0, 1'b1, 8'h00, 64'h0, 64'h0, 64'h0};
`else
        vecs[4]  = '{1'b0, 3'b010, 64'h02, 64'h0, 64'h1122334455667788, 0, 1'b0, 8'h3C, 64'h0, 64'h0, 64'h33445566};
        vecs[12] = '{1'b1, 3'b010, 64'h07, 64'hDEADBEEF, 64'h0, 0, 1'b0, 8'h80, 64'h0, 64'hEF00000000000000, 64'h0};
        vecs[14] = '{1'b0, 3'b011, 64'h03, 64'h0, 64'h1122334455667788, 2, 1'b0, 8'hF8, 64'h0, 64'h0, 64'h0000001122334455};
`endif
        vecs[5]  = '{1'b0, 3'b111, 64'h08, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'h0, 64'h0};
        vecs[6]  = '{1'b1, 3'b100, 64'h08, 64'h55, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'h0, 64'h0};
        vecs[7]  = '{1'b0, 3'b011, 64'h08, 64'h0, 64'hFEDCBA9876543210, 0, 1'b0, 8'hFF, 64'h08, 64'h0, 64'hFEDCBA9876543210};
        vecs[8]  = '{1'b0, 3'b001, 64'h1E, 64'h0, 64'h8001000000000000, 0, 1'b0, 8'hC0, 64'h18, 64'h0, 64'hFFFFFFFFFFFF8001};
        vecs[9]  = '{1'b0, 3'b101, 64'h1E, 64'h0, 64'h8001000000000000, 2, 1'b0, 8'hC0, 64'h18, 64'h0, 64'h8001};
        vecs[10] = '{1'b0, 3'b110, 64'h104, 64'h0, 64'hF000000000000000, 0, 1'b0, 8'hF0, 64'h100, 64'h0, 64'hF0000000};
        vecs[11] = '{1'b0, 3'b010, 64'h104, 64'h0, 64'hF000000000000000, 0, 1'b0, 8'hF0, 64'h100, 64'h0, 64'hFFFFFFFFF0000000};
        vecs[13] = '{1'b1, 3'b000, 64'h05, 64'hFFFFFFFFFFFFFF5A, 64'h0, 1, 1'b0, 8'h20, 64'h0, 64'hFFFF5A0000000000, 64'h0};

        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_be", {56'd0, mem_be}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_busy", {63'd0, busy}, 64'd0);
        chk("stray_ack_done", {63'd0, done}, 64'd0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // A req pulse during ISSUE is neither taken nor queued.
        req = 1'b1; we = 1'b0; funct3 = 3'b011; addr = 64'h40; wdata = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b111; addr = 64'h80;
        @(negedge clk);
        req = 1'b0;
        chk("ign_mem_addr", mem_addr, 64'h40);
        chk("ign_mem_we", {63'd0, mem_we}, 64'd0);
        chk("ign_busy", {63'd0, busy}, 64'd1);
        chk("ign_done", {63'd0, done}, 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        mem_ack = 1'b0;
        last_rd = 64'h0123456789ABCDEF;
        chk("ign_done_pulse", {63'd0, done}, 64'd1);
        chk("ign_err", {63'd0, err}, 64'd0);
        chk("ign_rdata", rdata, last_rd);
        @(negedge clk);
        chk("ign_not_queued_busy", {63'd0, busy}, 64'd0);
        chk("ign_not_queued_done", {63'd0, done}, 64'd0);

        // Reset mid-ISSUE abandons the access asynchronously.
        req = 1'b1; we = 1'b1; funct3 = 3'b011; addr = 64'h48; wdata = 64'h77;
        @(negedge clk);
        req = 1'b0;
        chk("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[7]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
